// File: rtl/playa_if.sv
// Lane-side signal bundle for the parking-lot gate controller.
// The controller uses the slave modport; the lane/detector side uses master.
interface playa_if #(
  parameter int N = 4
);
  logic         req_in;
  logic         req_out;
  logic         paso_in;
  logic         paso_out;
  logic         err_in;
  logic         gate_open;
  logic         grant_in;
  logic         grant_out;
  logic [N-1:0] ocupacion;
  logic         lleno;
  logic         falla;
  logic         timeout;

  modport master (
    output req_in, req_out, paso_in, paso_out, err_in,
    input  gate_open, grant_in, grant_out, ocupacion, lleno, falla, timeout
  );

  modport slave (
    input  req_in, req_out, paso_in, paso_out, err_in,
    output gate_open, grant_in, grant_out, ocupacion, lleno, falla, timeout
  );
endinterface

// File: rtl/playa_ctrl.sv
// Shared entry/exit barrier controller: round-robin lane arbitration,
// open/transit/guard sequencing, occupancy tracking and detector fault latch.
module playa_ctrl #(
  parameter int N            = 4,
  parameter int CAPACITY     = 10,
  parameter int GATE_CYCLES  = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic    clk,
  input  logic    reset,
  playa_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPEN_IN  = 3'd1,
    OPEN_OUT = 3'd2,
    GUARD    = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam int TMAX = (GATE_CYCLES > GUARD_CYCLES) ? GATE_CYCLES : GUARD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GATE_LAST  = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYCLES - 1);
  localparam logic [N-1:0]  CAP        = N'(CAPACITY);

  state_t        state;
  logic [TW-1:0] timer;
  logic [N-1:0]  occ;
  logic          last_out;
  logic          timeout_q;
  logic          elig_in;
  logic          elig_out;

  assign elig_in  = bus.req_in  && (occ < CAP);
  assign elig_out = bus.req_out && (occ != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      occ       <= '0;
      last_out  <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.err_in) begin
            state <= FAULT;
          end else if (elig_in && (!elig_out || last_out)) begin
            state    <= OPEN_IN;
            last_out <= 1'b0;
            timer    <= '0;
          end else if (elig_out) begin
            state    <= OPEN_OUT;
            last_out <= 1'b1;
            timer    <= '0;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          // A transit on the expiry cycle wins over the timeout.
          if (bus.err_in) begin
            state <= FAULT;
          end else if ((state == OPEN_IN) && bus.paso_in) begin
            occ   <= occ + 1'b1;
            state <= GUARD;
            timer <= '0;
          end else if ((state == OPEN_OUT) && bus.paso_out) begin
            occ   <= occ - 1'b1;
            state <= GUARD;
            timer <= '0;
          end else if (timer == GATE_LAST) begin
            state     <= GUARD;
            timer     <= '0;
            timeout_q <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GUARD: begin
          if (bus.err_in) begin
            state <= FAULT;
          end else if (timer == GUARD_LAST) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FAULT: begin
          // Leave only once both lanes are clear, so no car is mid-transit.
          if (!bus.err_in && !bus.req_in && !bus.req_out) begin
            state <= GUARD;
            timer <= '0;
          end
        end
        default: state <= FAULT;
      endcase
    end
  end

  assign bus.gate_open = (state == OPEN_IN) || (state == OPEN_OUT);
  assign bus.grant_in  = (state == OPEN_IN);
  assign bus.grant_out = (state == OPEN_OUT);
  assign bus.falla     = (state == FAULT);
  assign bus.timeout   = timeout_q;
  assign bus.ocupacion = occ;
  assign bus.lleno     = (occ == CAP);

endmodule
